// File: rtl/sram_confreg_resp.sv
// Single-port data RAM plus a small memory-mapped register window, one-cycle read-first response.
// Optional macro SRAM_CONFREG_TIMER_EN turns the TIMER register into a free-running counter.
module sram_confreg_resp #(
  parameter int          RAM_AW    = 12,
  parameter logic [15:0] MMIO_BASE = 16'hBFAF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch_in,
  output logic [15:0] led_out,
  output logic [31:0] num_out
);

  localparam logic [13:0] OFF_LED = 14'h0;
  localparam logic [13:0] OFF_SW  = 14'h1;
  localparam logic [13:0] OFF_SCR = 14'h2;
  localparam logic [13:0] OFF_TMR = 14'h3;
  localparam logic [13:0] OFF_NUM = 14'h4;

  logic [31:0] mem_q [0:(1<<RAM_AW)-1];

  logic [31:0] rdata_q;
  logic [15:0] led_q, led_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] num_q, num_d;
  logic [15:0] sw_meta_q, sw_sync_q;

  logic              is_mmio;
  logic [13:0]       word_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr_en;
  logic              mmio_wr;
  logic [31:0]       mmio_rdata;
  logic [31:0]       rd_d;
  logic [1:0]        unused_addr_lsb;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  assign is_mmio         = (data_sram_addr[31:16] == MMIO_BASE);
  assign word_off        = data_sram_addr[15:2];
  assign ram_idx         = data_sram_addr[RAM_AW+1:2];
  assign unused_addr_lsb = data_sram_addr[1:0];
  assign wr_en           = data_sram_en && (data_sram_wen != 4'b0000);
  assign mmio_wr         = wr_en && is_mmio;

  always_comb begin
    mmio_rdata = 32'h0;
    case (word_off)
      OFF_LED: mmio_rdata = {16'h0, led_q};
      OFF_SW:  mmio_rdata = {16'h0, sw_sync_q};
      OFF_SCR: mmio_rdata = scratch_q;
      OFF_TMR: mmio_rdata = timer_q;
      OFF_NUM: mmio_rdata = num_q;
      default: mmio_rdata = 32'h0;
    endcase
  end

  // Read-first: the response always reflects state before this cycle's write lands.
  assign rd_d = is_mmio ? mmio_rdata : mem_q[ram_idx];

  always_comb begin
    led_d     = led_q;
    scratch_d = scratch_q;
    num_d     = num_q;
`ifdef SRAM_CONFREG_TIMER_EN
    timer_d   = timer_q + 32'd1;
`else
    timer_d   = timer_q;
`endif
    if (mmio_wr) begin
      case (word_off)
        OFF_LED: led_d     = {data_sram_wen[1] ? data_sram_wdata[15:8] : led_q[15:8],
                              data_sram_wen[0] ? data_sram_wdata[7:0]  : led_q[7:0]};
        OFF_SCR: scratch_d = byte_merge(scratch_q, data_sram_wdata, data_sram_wen);
        OFF_TMR: timer_d   = byte_merge(timer_q, data_sram_wdata, data_sram_wen);
        OFF_NUM: num_d     = byte_merge(num_q, data_sram_wdata, data_sram_wen);
        default: ;
      endcase
    end
  end

  // RAM array carries no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_en && !is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) mem_q[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q   <= 32'h0;
      led_q     <= 16'h0;
      scratch_q <= 32'h0;
      timer_q   <= 32'h0;
      num_q     <= 32'h0;
      sw_meta_q <= 16'h0;
      sw_sync_q <= 16'h0;
    end else begin
      sw_meta_q <= switch_in;
      sw_sync_q <= sw_meta_q;
      led_q     <= led_d;
      scratch_q <= scratch_d;
      timer_q   <= timer_d;
      num_q     <= num_d;
      if (data_sram_en) rdata_q <= rd_d;
    end
  end

  assign data_sram_rdata = rdata_q;
  assign led_out         = led_q;
  assign num_out         = num_q;

endmodule
